// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: writes a valid/ready stream into fifo_mem and
// prefetches into a 2-entry first-word-fall-through output buffer.
package fifo_pkg;
    parameter int ADDR_WIDTH = 4;
    parameter int DATA_WIDTH = 8;
endpackage

module fifo_sync_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic [ADDR_WIDTH:0]   w_mem_cnt_nxt;
    logic                  r_inflight;
    logic [1:0]            r_out_occ;
    logic [1:0]            w_out_occ_nxt;
    logic [1:0]            w_base;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;
    logic [ADDR_WIDTH+1:0] r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_pending;

    // Full is judged on the registered memory count only, keeping m_ready off the s_ready path.
    assign s_ready     = !rst && (r_mem_cnt != DEPTH);
    assign w_push      = s_valid && s_ready;
    assign m_valid     = (r_out_occ != 2'd0);
    assign m_data      = r_buf0;
    assign w_pop       = m_valid && m_ready;
    assign w_pending   = {1'b0, r_out_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_mem_cnt != '0) && (w_pending < 3'd2);
    assign mem_wr_en   = w_push;
    assign mem_wr_addr = r_wr_ptr;
    assign mem_wr_data = s_data;
    assign mem_rd_addr = r_rd_ptr;
    assign count       = r_count;

    always_comb begin
        w_base     = r_out_occ - {1'b0, w_pop};
        w_buf0_nxt = w_pop ? r_buf1 : r_buf0;
        w_buf1_nxt = r_buf1;
        // The returning read lands in the first slot left free after this cycle's pop.
        if (r_inflight) begin
            if (w_base == 2'd0) begin
                w_buf0_nxt = mem_rd_data;
            end else begin
                w_buf1_nxt = mem_rd_data;
            end
        end
        w_out_occ_nxt = w_base + {1'b0, r_inflight};
        w_mem_cnt_nxt = r_mem_cnt + {ADDR_WIDTH'(0), w_push} - {ADDR_WIDTH'(0), w_issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_out_occ  <= 2'd0;
            r_buf0     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_mem_cnt  <= w_mem_cnt_nxt;
            r_inflight <= w_issue;
            r_out_occ  <= w_out_occ_nxt;
            r_buf0     <= w_buf0_nxt;
            r_count    <= {1'b0, w_mem_cnt_nxt}
                        + {{(ADDR_WIDTH+1){1'b0}}, w_issue}
                        + {ADDR_WIDTH'(0), w_out_occ_nxt};
        end
    end

    always_ff @(posedge clk) begin
        r_buf1 <= w_buf1_nxt;
    end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: two instances (ADDR_WIDTH 3 and 2), each with a
// behavioural fifo_mem, checked against a data scoreboard and directed steps.
module tb_fifo_sync_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: ADDR_WIDTH=3 (DEPTH 8, capacity 10)
    logic       a_s_valid = 1'b0, a_s_ready, a_m_valid, a_m_ready = 1'b0, a_mem_wr_en;
    logic [7:0] a_s_data = '0, a_m_data, a_mem_wr_data, a_mem_rd_data;
    logic [2:0] a_mem_wr_addr, a_mem_rd_addr;
    logic [4:0] a_count;
    logic [7:0] mem_a [8];

    fifo_sync_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) u_a (
        .clk(clk), .rst(rst),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .mem_wr_en(a_mem_wr_en), .mem_wr_addr(a_mem_wr_addr), .mem_wr_data(a_mem_wr_data),
        .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data), .count(a_count)
    );

    always @(posedge clk) begin
        if (a_mem_wr_en) mem_a[a_mem_wr_addr] <= a_mem_wr_data;
        a_mem_rd_data <= mem_a[a_mem_rd_addr];
    end

    // Instance B: ADDR_WIDTH=2 (DEPTH 4) for pointer wrap
    logic       b_s_valid = 1'b0, b_s_ready, b_m_valid, b_m_ready = 1'b0, b_mem_wr_en;
    logic [7:0] b_s_data = '0, b_m_data, b_mem_wr_data, b_mem_rd_data;
    logic [1:0] b_mem_wr_addr, b_mem_rd_addr;
    logic [3:0] b_count;
    logic [7:0] mem_b [4];

    fifo_sync_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) u_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .mem_wr_en(b_mem_wr_en), .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data),
        .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data), .count(b_count)
    );

    always @(posedge clk) begin
        if (b_mem_wr_en) mem_b[b_mem_wr_addr] <= b_mem_wr_data;
        b_mem_rd_data <= mem_b[b_mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes sampled mid-cycle, i.e. the transfer about to happen at the next edge
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int pushes_a = 0, pops_a = 0, pops_b = 0;
    logic [1:0] eb_wr = '0, eb_rd = '0;
    logic [7:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            pushes_a = 0;
            eb_wr    = '0;
            eb_rd    = '0;
        end else begin
            if (a_mem_wr_en) chk("a_wr_addr", a_mem_wr_addr, 32'(pushes_a[2:0]));
            if (a_s_valid && a_s_ready) begin
                qa.push_back(a_s_data);
                pushes_a++;
            end
            if (a_m_valid && a_m_ready) begin
                chk("a_pop_expected", 32'(qa.size() != 0), 1);
                if (qa.size() != 0) begin
                    exp_w = qa.pop_front();
                    chk("a_data", a_m_data, exp_w);
                end
                pops_a++;
            end
            if (b_mem_wr_en) begin
                chk("b_wr_addr", b_mem_wr_addr, eb_wr);
                eb_wr = eb_wr + 2'd1;
            end
            if (b_mem_rd_addr != eb_rd) begin
                eb_rd = eb_rd + 2'd1;
                chk("b_rd_addr", b_mem_rd_addr, eb_rd);
            end
            if (b_s_valid && b_s_ready) qb.push_back(b_s_data);
            if (b_m_valid && b_m_ready) begin
                chk("b_pop_expected", 32'(qb.size() != 0), 1);
                if (qb.size() != 0) begin
                    exp_w = qb.pop_front();
                    chk("b_data", b_m_data, exp_w);
                end
                pops_b++;
            end
        end
    end

    task automatic drain_a();
        int g;
        a_m_ready = 1'b1;
        g = 0;
        while (a_count != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("a_drain_count", a_count, 0);
        chk("a_drain_mvalid", a_m_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int base;
        int sent;
        int g;
        logic w;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_count", a_count, 0);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_data", a_m_data, 8'h00);
        chk("rst_wr_en", a_mem_wr_en, 0);
        chk("rst_b_s_ready", b_s_ready, 0);
        rst = 1'b0;
        #1;
        chk("rel_s_ready", a_s_ready, 1);

        // Single word, 3-cycle latency
        a_s_valid = 1'b1;
        a_s_data  = 8'hA5;
        a_m_ready = 1'b1;
        tick();
        a_s_valid = 1'b0;
        chk("single_cnt1", a_count, 1);
        chk("single_mv1", a_m_valid, 0);
        tick();
        chk("single_mv2", a_m_valid, 0);
        tick();
        chk("single_mv3", a_m_valid, 1);
        chk("single_data", a_m_data, 8'hA5);
        chk("single_cnt3", a_count, 1);
        tick();
        chk("single_mv4", a_m_valid, 0);
        chk("single_cnt4", a_count, 0);

        // Fill with consumer stalled: DEPTH + 2 = 10 words
        a_m_ready = 1'b0;
        d = 0;
        for (int k = 0; k < 20; k++) begin
            a_s_valid = 1'b1;
            a_s_data  = 8'(d);
            w = a_s_ready;
            tick();
            if (w) d++;
        end
        a_s_valid = 1'b0;
        chk("fill_accepted", d, 10);
        chk("fill_count", a_count, 10);
        chk("fill_s_ready", a_s_ready, 0);
        chk("fill_head", a_m_data, 8'h00);
        a_m_ready = 1'b1;
        #1;
        chk("fill_full_pop_s_ready", a_s_ready, 0);
        tick();
        chk("fill_reopen", a_s_ready, 1);
        drain_a();
        chk("fill_pops", pops_a, 11);

        // Streaming 100 words
        for (int k = 1; k <= 106; k++) begin
            if (k <= 100) begin
                a_s_valid = 1'b1;
                a_s_data  = 8'(64 + k - 1);
            end else begin
                a_s_valid = 1'b0;
            end
            tick();
            chk("stream_mvalid", a_m_valid, 32'(k >= 3 && k <= 102));
            chk("stream_count_le3", 32'(a_count <= 5'd3), 1);
        end
        drain_a();
        chk("stream_pops", pops_a, 111);

        // Stall stability
        a_m_ready = 1'b0;
        base = pushes_a;
        for (int k = 0; k < 4; k++) begin
            a_s_valid = 1'b1;
            a_s_data  = 8'(32 + k);
            tick();
        end
        a_s_valid = 1'b0;
        repeat (4) tick();
        chk("stall_count", a_count, 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_mvalid", a_m_valid, 1);
            chk("stall_data", a_m_data, 8'h20);
            chk("stall_rd_addr", a_mem_rd_addr, 32'((base + 2) % 8));
        end
        drain_a();

        // Pointer wrap on the DEPTH-4 instance with random consumer
        sent = 0;
        g = 0;
        while (sent < 20 && g < 400) begin
            b_s_valid = 1'b1;
            b_s_data  = 8'(128 + sent);
            b_m_ready = 1'($urandom_range(0, 1));
            w = b_s_ready;
            tick();
            if (w) sent++;
            g++;
        end
        b_s_valid = 1'b0;
        chk("wrap_sent", sent, 20);
        b_m_ready = 1'b1;
        g = 0;
        while (b_count != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("wrap_count", b_count, 0);
        chk("wrap_pops", pops_b, 20);

        // Reset mid-operation with 6 words held
        a_m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a_s_valid = 1'b1;
            a_s_data  = 8'(80 + k);
            tick();
        end
        a_s_valid = 1'b0;
        repeat (3) tick();
        chk("mid_held", a_count, 6);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", a_s_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_count", a_count, 0);
        chk("mid_mvalid", a_m_valid, 0);
        chk("mid_s_ready", a_s_ready, 1);
        a_s_valid = 1'b1;
        a_s_data  = 8'h3C;
        a_m_ready = 1'b1;
        tick();
        a_s_valid = 1'b0;
        tick();
        chk("mid_mv2", a_m_valid, 0);
        tick();
        chk("mid_mv3", a_m_valid, 1);
        chk("mid_data", a_m_data, 8'h3C);
        tick();
        chk("mid_alone_mv", a_m_valid, 0);
        chk("mid_alone_cnt", a_count, 0);
        chk("mid_q_empty", qa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
